// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - DEFAULT_WIDTH : default operand/result width
//   - OP_*          : opcode values
//   - state_t       : control FSM state encoding
package alu_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_SUB  = 1;
   localparam int unsigned OP_MUL  = 2;
   localparam int unsigned OP_OR   = 3;
   localparam int unsigned OP_AND  = 4;
   localparam int unsigned OP_NOR  = 5;
   localparam int unsigned OP_NAND = 6;
   localparam int unsigned OP_XOR  = 7;
   localparam int unsigned OP_SHL  = 8;
   localparam int unsigned OP_SHR  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, one multiplier bit per step.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture operands, clear accumulator and step counter
//   step          : fold in partial product for the current bit, advance counter
//   multiplicand  : operand A (captured on load)
//   multiplier    : operand B (captured on load)
//   acc           : accumulator including the current step's partial product
//   last          : current step is the final one (counter == WIDTH-1)
module seq_alu_mul
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned ACC_W = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic [ACC_W-1:0] acc,
   output logic             last
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] addend;
   logic [CW-1:0]    count_q;

   always_comb begin
      addend = '0;
      if (mplier_q[count_q]) begin
         addend = ACC_W'(mcand_q) << count_q;
      end
   end

   // Exposing the post-step sum lets the owner capture the final product on
   // the same edge that performs the last step.
   assign acc  = acc_q + addend;
   assign last = (count_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (load) begin
         mcand_q  <= multiplicand;
         mplier_q <= multiplier;
         acc_q    <= '0;
         count_q  <= '0;
      end else if (step) begin
         acc_q   <= acc;
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a start/done handshake. Logic, add/sub and
// shifts complete in one cycle; multiply iterates over WIDTH cycles.
// Optional macro SEQ_ALU_OVF_EN adds the ovf output and widens the multiply
// accumulator to 2*WIDTH.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, honoured only in IDLE
//   aluoperation    : opcode, sampled with start
//   data1, data2    : operands A/B, sampled with start
//   busy            : multiply in progress
//   done            : one-cycle completion pulse
//   result          : registered result, held until the next completion
//   zero, lt, gt    : result==0, A<B, A>B (unsigned), registered with result
//   ovf             : (SEQ_ALU_OVF_EN only) carry/borrow/high product bits
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  aluoperation,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             lt,
   output logic             gt
`ifdef SEQ_ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef SEQ_ALU_OVF_EN
   localparam int unsigned ACC_W = 2 * WIDTH;
`else
   localparam int unsigned ACC_W = WIDTH;
`endif

   state_t           state_q, state_d;
   logic             accept, is_mul;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] alu_res;
   logic [SW-1:0]    shamt;
   logic [ACC_W-1:0] mul_acc;
   logic             mul_last;
   logic [WIDTH-1:0] result_q;
   logic             done_q, zero_q, lt_q, gt_q;
`ifdef SEQ_ALU_OVF_EN
   logic             alu_ovf, ovf_q;
`endif

   assign accept = (state_q == IDLE) && start;
   assign is_mul = (aluoperation == OP_W'(OP_MUL));
   assign shamt  = data2[SW-1:0];

   seq_alu_mul #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
   ) u_mul (
      .clk          (clk),
      .rst          (rst),
      .load         (accept && is_mul),
      .step         (state_q == MUL),
      .multiplicand (data1),
      .multiplier   (data2),
      .acc          (mul_acc),
      .last         (mul_last)
   );

   // Single-cycle operations, evaluated on the live inputs at accept.
   always_comb begin
      alu_res = '0;
`ifdef SEQ_ALU_OVF_EN
      alu_ovf = 1'b0;
`endif
      case (aluoperation)
         OP_W'(OP_ADD): begin
            alu_res = data1 + data2;
`ifdef SEQ_ALU_OVF_EN
            // Wrapped sum below an addend means a carry out.
            alu_ovf = (data1 + data2) < data1;
`endif
         end
         OP_W'(OP_SUB): begin
            alu_res = data1 - data2;
`ifdef SEQ_ALU_OVF_EN
            alu_ovf = data1 < data2;
`endif
         end
         OP_W'(OP_OR):   alu_res = data1 | data2;
         OP_W'(OP_AND):  alu_res = data1 & data2;
         OP_W'(OP_NOR):  alu_res = ~(data1 | data2);
         OP_W'(OP_NAND): alu_res = ~(data1 & data2);
         OP_W'(OP_XOR):  alu_res = data1 ^ data2;
         OP_W'(OP_SHL):  alu_res = data1 << shamt;
         OP_W'(OP_SHR):  alu_res = data1 >> shamt;
         default:        alu_res = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = is_mul ? MUL : DONE;
         MUL:     if (mul_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: DONE only carries the done pulse, so busy covers MUL alone.
   always_comb begin
      busy = (state_q == MUL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         zero_q   <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            a_q <= data1;
            b_q <= data2;
            if (!is_mul) begin
               result_q <= alu_res;
               zero_q   <= (alu_res == '0);
               lt_q     <= data1 < data2;
               gt_q     <= data1 > data2;
               done_q   <= 1'b1;
`ifdef SEQ_ALU_OVF_EN
               ovf_q    <= alu_ovf;
`endif
            end
         end else if ((state_q == MUL) && mul_last) begin
            result_q <= mul_acc[WIDTH-1:0];
            zero_q   <= (mul_acc[WIDTH-1:0] == '0);
            lt_q     <= a_q < b_q;
            gt_q     <= a_q > b_q;
            done_q   <= 1'b1;
`ifdef SEQ_ALU_OVF_EN
            ovf_q    <= |mul_acc[ACC_W-1:WIDTH];
`endif
         end
      end
   end

   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign lt     = lt_q;
   assign gt     = gt_q;
`ifdef SEQ_ALU_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule
